toast_mem_arbiter: RTL and testbench

- Shares one single-port synchronous memory between the core's instruction-fetch port and data port, so one unified program/data image serves both.
- Sits between toast_top (IMEM/DMEM ports) and the memory macro.
- Grants at most one access per cycle. Data has priority by default, and a starvation limit guarantees fetch progress.
- Routes each read response back to the requester that issued it, one cycle after grant.

---
 rtl/toast_mem_arbiter.sv | 114 +++++++++++
 tb/tb_toast_mem_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/toast_mem_arbiter.sv
// Single-port memory arbiter between fetch and data ports; data has priority with a fetch starvation limit.
// Define TOAST_ARB_ROUND_ROBIN_EN to make contended grants strictly alternate instead.
module toast_mem_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_STREAK_MAX = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [31:0]           if_rdata_o,
  input  logic                  d_req_i,
  input  logic [3:0]            d_be_i,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic [31:0]           d_wdata_i,
  output logic                  d_gnt_o,
  output logic                  d_rvalid_o,
  output logic [31:0]           d_rdata_o,
  input  logic                  mem_ready_i,
  output logic                  mem_en_o,
  output logic [3:0]            mem_be_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  input  logic [31:0]           mem_rdata_i
);
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DATA} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_DATA} owner_t;

  localparam logic [3:0] STREAK_MAX = 4'(DATA_STREAK_MAX);

  state_t                state, state_nxt;
  owner_t                rd_owner, rd_owner_nxt;
  logic [3:0]            streak, streak_nxt;
  logic                  gnt_f, gnt_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q, if_rdata_q, d_rdata_q;

  // Grants are forced low while reset is asserted so every output reads zero.
  always_comb begin
    gnt_f = 1'b0;
    gnt_d = 1'b0;
    if (!rst_i && mem_ready_i) begin
      if (if_req_i && d_req_i) begin
`ifdef TOAST_ARB_ROUND_ROBIN_EN
        if (state == S_DATA) gnt_f = 1'b1;
        else                 gnt_d = 1'b1;
`else
        if (streak >= STREAK_MAX) gnt_f = 1'b1;
        else                      gnt_d = 1'b1;
`endif
      end else begin
        gnt_f = if_req_i;
        gnt_d = d_req_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      streak     <= '0;
      rd_owner   <= OWN_NONE;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state    <= state_nxt;
      streak   <= streak_nxt;
      rd_owner <= rd_owner_nxt;
      if (gnt_f || gnt_d) begin
        addr_q  <= mem_addr_o;
        wdata_q <= mem_wdata_o;
      end
      if (if_rvalid_o) if_rdata_q <= mem_rdata_i;
      if (d_rvalid_o)  d_rdata_q  <= mem_rdata_i;
    end
  end

  // rd_owner marks only the read granted last cycle, so each read yields exactly one rvalid.
  always_comb begin
    state_nxt    = state;
    streak_nxt   = streak;
    rd_owner_nxt = OWN_NONE;
    if (gnt_f)            state_nxt = S_FETCH;
    else if (gnt_d)       state_nxt = S_DATA;
    else if (mem_ready_i) state_nxt = S_IDLE;
    if (gnt_f)                          rd_owner_nxt = OWN_FETCH;
    else if (gnt_d && d_be_i == 4'b0)   rd_owner_nxt = OWN_DATA;
`ifdef TOAST_ARB_ROUND_ROBIN_EN
    streak_nxt = '0;
`else
    if (mem_ready_i) begin
      if (gnt_f || !if_req_i)             streak_nxt = '0;
      else if (gnt_d && streak < STREAK_MAX) streak_nxt = streak + 4'd1;
    end
`endif
  end

  always_comb begin
    if_gnt_o    = gnt_f;
    d_gnt_o     = gnt_d;
    mem_en_o    = gnt_f | gnt_d;
    mem_be_o    = gnt_d ? d_be_i : 4'b0;
    mem_addr_o  = gnt_d ? d_addr_i : (gnt_f ? if_addr_i : addr_q);
    mem_wdata_o = gnt_d ? d_wdata_i : wdata_q;
    if_rvalid_o = (rd_owner == OWN_FETCH);
    d_rvalid_o  = (rd_owner == OWN_DATA);
    if_rdata_o  = if_rvalid_o ? mem_rdata_i : if_rdata_q;
    d_rdata_o   = d_rvalid_o  ? mem_rdata_i : d_rdata_q;
  end
endmodule

// File: tb/tb_toast_mem_arbiter.sv
// Scoreboard bench for toast_mem_arbiter: driver pushes expected read data on grant, monitor pops on rvalid.
module tb_toast_mem_arbiter;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i, if_gnt_o, if_rvalid_o;
  logic [31:0] if_addr_i, if_rdata_o;
  logic        d_req_i, d_gnt_o, d_rvalid_o;
  logic [3:0]  d_be_i, mem_be_o;
  logic [31:0] d_addr_i, d_wdata_i, d_rdata_o;
  logic        mem_ready_i, mem_en_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  logic [31:0] mem [0:4095];
  logic [31:0] if_q[$];
  logic [31:0] d_q[$];
  int total = 0;
  int passed = 0;

  toast_mem_arbiter #(.ADDR_WIDTH(32), .DATA_STREAK_MAX(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_be_i(d_be_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .mem_ready_i(mem_ready_i), .mem_en_o(mem_en_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural single-port memory: one-cycle read latency, byte-enabled writes.
  always @(posedge clk_i) begin
    if (mem_en_o) begin
      if (mem_be_o == 4'b0) mem_rdata_i <= mem[mem_addr_o[13:2]];
      else for (int b = 0; b < 4; b++)
        if (mem_be_o[b]) mem[mem_addr_o[13:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
  endtask

  always @(negedge clk_i) begin
    if (if_rvalid_o) begin
      if (if_q.size() == 0) chk("if_rvalid_unexpected", 32'd1, 32'd0);
      else chk("if_rdata", if_rdata_o, if_q.pop_front());
    end
    if (d_rvalid_o) begin
      if (d_q.size() == 0) chk("d_rvalid_unexpected", 32'd1, 32'd0);
      else chk("d_rdata", d_rdata_o, d_q.pop_front());
    end
  end

  // One bus cycle: drive, check grants mid-cycle, enqueue expected read data.
  task automatic cyc(input logic fr, input logic [31:0] fa, input logic dr, input logic [3:0] be,
                     input logic [31:0] da, input logic [31:0] dw, input logic rdy,
                     input logic ef, input logic ed, input logic [31:0] f_data, input logic [31:0] d_data);
    if_req_i = fr; if_addr_i = fa; d_req_i = dr; d_be_i = be; d_addr_i = da; d_wdata_i = dw;
    mem_ready_i = rdy;
    @(negedge clk_i);
    chk("if_gnt", {31'b0, if_gnt_o}, {31'b0, ef});
    chk("d_gnt", {31'b0, d_gnt_o}, {31'b0, ed});
    chk("mem_en", {31'b0, mem_en_o}, {31'b0, ef | ed});
    chk("mem_be", {28'b0, mem_be_o}, {28'b0, ed ? be : 4'b0});
    if (ef && if_gnt_o) if_q.push_back(f_data);
    if (ed && d_gnt_o && be == 4'b0) d_q.push_back(d_data);
    @(posedge clk_i); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_if_gnt"}, {31'b0, if_gnt_o}, 32'd0);
    chk({tag, "_d_gnt"}, {31'b0, d_gnt_o}, 32'd0);
    chk({tag, "_if_rvalid"}, {31'b0, if_rvalid_o}, 32'd0);
    chk({tag, "_d_rvalid"}, {31'b0, d_rvalid_o}, 32'd0);
    chk({tag, "_mem_en"}, {31'b0, mem_en_o}, 32'd0);
    chk({tag, "_mem_be"}, {28'b0, mem_be_o}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr_o, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata_o, 32'd0);
    chk({tag, "_if_rdata"}, if_rdata_o, 32'd0);
    chk({tag, "_d_rdata"}, d_rdata_o, 32'd0);
  endtask

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] W10  = 32'hDEAD_BEEF;
  localparam logic [31:0] W2000 = 32'h1122_3344;
  localparam logic [31:0] W2004 = 32'hCAFE_F00D;

  // Expected contention order, 1 = fetch, LSB first.
`ifdef TOAST_ARB_ROUND_ROBIN_EN
  localparam logic [9:0] CONT_F  = 10'b1010101010;
  localparam logic [1:0] STALL_PRE = 2'b10;
  localparam logic [2:0] STALL_POST = 3'b010;
`else
  localparam logic [9:0] CONT_F  = 10'b1000010000;
  localparam logic [1:0] STALL_PRE = 2'b00;
  localparam logic [2:0] STALL_POST = 3'b100;
`endif

  initial begin
    logic [9:0] cf;
    logic [1:0] sp;
    logic [2:0] so;
    cf = CONT_F; sp = STALL_PRE; so = STALL_POST;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    mem[0] = NOP; mem[1] = NOP; mem[2] = NOP;
    mem[4] = W10; mem['h800] = W2000; mem['h801] = W2004;
    rst_i = 1'b1; if_req_i = 0; if_addr_i = 0; d_req_i = 0; d_be_i = 0;
    d_addr_i = 0; d_wdata_i = 0; mem_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 chk_zero("reset");
    rst_i = 1'b0;
    idle(1);

    // Fetch-only stream, pipelined back-to-back
    cyc(1, 32'h0, 0, 0, 0, 0, 1, 1, 0, NOP, 0);
    cyc(1, 32'h4, 0, 0, 0, 0, 1, 1, 0, NOP, 0);
    cyc(1, 32'h8, 0, 0, 0, 0, 1, 1, 0, NOP, 0);
    idle(1);

    // Contention for 10 cycles
    for (int i = 0; i < 10; i++)
      cyc(1, 32'h10, 1, 0, 32'h2004, 0, 1, cf[i], !cf[i], W10, W2004);
    idle(1);

    // Mixed return: data read then fetch read on consecutive cycles
    cyc(0, 0, 1, 0, 32'h2004, 0, 1, 0, 1, 0, W2004);
    cyc(1, 32'h10, 0, 0, 0, 0, 1, 1, 0, W10, 0);
    idle(1);

    // Write-then-fetch hazard on the same word
    cyc(1, 32'h2000, 1, 4'b0001, 32'h2000, 32'h0000_00AB, 1, 0, 1, 0, 0);
    cyc(1, 32'h2000, 0, 0, 0, 0, 1, 1, 0, 32'h1122_33AB, 0);
    idle(1);

    // Stall with both requests held; streak must survive the stall
    for (int i = 0; i < 2; i++)
      cyc(1, 32'h10, 1, 0, 32'h2004, 0, 1, sp[i], !sp[i], W10, W2004);
    for (int i = 0; i < 3; i++)
      cyc(1, 32'h10, 1, 0, 32'h2004, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      cyc(1, 32'h10, 1, 0, 32'h2004, 0, 1, so[i], !so[i], W10, W2004);
    idle(2);

    // Reset while a data read is in flight: response must be discarded
    if_req_i = 1'b1; if_addr_i = 32'h10; d_req_i = 1'b1; d_be_i = 0; d_addr_i = 32'h2004;
    mem_ready_i = 1'b1;
    @(negedge clk_i);
    chk("pre_rst_d_gnt", {31'b0, d_gnt_o}, 32'd1);
    @(posedge clk_i); #1;
    chk("pre_rst_d_rvalid", {31'b0, d_rvalid_o}, 32'd1);
    rst_i = 1'b1;
    #1 chk_zero("mid_reset");
    @(posedge clk_i); #1;
    if_req_i = 0; d_req_i = 0;
    rst_i = 1'b0;
    idle(3);

    chk("if_q_drained", if_q.size(), 32'd0);
    chk("d_q_drained", d_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
